reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 128 ++++++++++++
 tb/tb_reset_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Power-on / soft-restart reset sequencer: holds every datapath stage in reset,
// then releases stages one at a time, waiting for each to report ready.
module reset_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 3,
    localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  soft_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] reset_out,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  seq_error,
    output logic [RW-1:0]         retry_count,
    output logic [IW-1:0]         stage_index
);
    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_ASSERT = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    logic [1:0]            state, state_n;
    logic [HCW-1:0]        hold_cnt, hold_cnt_n;
    logic [TCW-1:0]        wait_cnt, wait_cnt_n;
    logic [IW-1:0]         idx_n;
    logic [RW-1:0]         retry_n;
    logic [NUM_STAGES-1:0] reset_out_n;

    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        wait_cnt_n = wait_cnt;
        idx_n      = stage_index;
        retry_n    = retry_count;
        if (soft_reset_req) begin
            state_n    = ST_ASSERT;
            hold_cnt_n = '0;
            wait_cnt_n = '0;
            idx_n      = '0;
            retry_n    = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (hold_cnt == HCW'(HOLD_CYCLES - 1)) begin
                        state_n    = ST_WAIT;
                        idx_n      = '0;
                        wait_cnt_n = '0;
                    end else begin
                        hold_cnt_n = hold_cnt + HCW'(1);
                    end
                end
                ST_WAIT: begin
                    // Ready in the final allowed cycle wins over the timeout.
                    if (stage_ready[stage_index]) begin
                        if (stage_index == IW'(NUM_STAGES - 1)) begin
                            state_n = ST_DONE;
                            idx_n   = '0;
                            retry_n = '0;
                        end else begin
                            idx_n      = stage_index + IW'(1);
                            wait_cnt_n = '0;
                        end
                    end else if (wait_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                        idx_n = '0;
                        if (retry_count < RW'(MAX_RETRIES)) begin
                            retry_n    = retry_count + RW'(1);
                            state_n    = ST_ASSERT;
                            hold_cnt_n = '0;
                        end else begin
                            state_n = ST_ERROR;
                        end
                    end else begin
                        wait_cnt_n = wait_cnt + TCW'(1);
                    end
                end
                ST_DONE: begin
                    if (!(&stage_ready)) begin
                        state_n    = ST_ASSERT;
                        hold_cnt_n = '0;
                        retry_n    = '0;
                    end
                end
                default: ;
            endcase
        end

        // Outputs are registered from the next state so they change with it.
        reset_out_n = '1;
        if (state_n == ST_DONE) begin
            reset_out_n = '0;
        end else if (state_n == ST_WAIT) begin
            for (int i = 0; i < NUM_STAGES; i++)
                reset_out_n[i] = (i > int'(idx_n));
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state       <= ST_ASSERT;
            hold_cnt    <= '0;
            wait_cnt    <= '0;
            stage_index <= '0;
            retry_count <= '0;
            reset_out   <= '1;
            seq_busy    <= 1'b1;
            seq_done    <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            state       <= state_n;
            hold_cnt    <= hold_cnt_n;
            wait_cnt    <= wait_cnt_n;
            stage_index <= idx_n;
            retry_count <= retry_n;
            reset_out   <= reset_out_n;
            seq_busy    <= (state_n == ST_ASSERT) || (state_n == ST_WAIT);
            seq_done    <= (state_n == ST_DONE);
            seq_error   <= (state_n == ST_ERROR);
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized scoreboard bench for reset_sequencer: a phase/elapsed-time model
// predicts each cycle's outputs; a monitor compares them on the falling edge.
module tb_reset_sequencer;
    localparam int N = 3, H = 4, T = 8, R = 2;

    typedef struct packed {
        logic [2:0] ro;
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] rc;
        logic [1:0] si;
    } obs_t;

    localparam int PH_HOLD = 0, PH_WAIT = 1, PH_DONE = 2, PH_ERR = 3;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       soft_reset_req = 1'b0;
    logic [2:0] stage_ready = 3'b000;
    logic [2:0] reset_out;
    logic       seq_busy, seq_done, seq_error;
    logic [1:0] retry_count, stage_index;

    reset_sequencer #(.NUM_STAGES(N), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T), .MAX_RETRIES(R)) dut (
        .clk_in(clk_in), .reset(reset), .soft_reset_req(soft_reset_req),
        .stage_ready(stage_ready), .reset_out(reset_out), .seq_busy(seq_busy),
        .seq_done(seq_done), .seq_error(seq_error), .retry_count(retry_count),
        .stage_index(stage_index)
    );

    always #5 clk_in = ~clk_in;

    obs_t exp_q[$];
    int   errors = 0, checks = 0, cycle = 0;

    // Model: phase, cycles elapsed in the phase, stage under release, retries.
    int ph = PH_HOLD, elapsed = 0, k = 0, retries = 0;
    // Stage behaviour driving stage_ready.
    int   age[3] = '{0, 0, 0};
    int   dly[3] = '{2, 2, 2};
    logic [2:0] stuck = 3'b000, drop = 3'b000, cur_ro = 3'b111;
    logic all_hi = 1'b0;

    task automatic model_edge(input logic r, input logic s, input logic [2:0] rdy);
        if (r || s) begin
            ph = PH_HOLD; elapsed = 0; k = 0; retries = 0;
        end else if (ph == PH_HOLD) begin
            elapsed++;
            if (elapsed == H) begin ph = PH_WAIT; k = 0; elapsed = 0; end
        end else if (ph == PH_WAIT) begin
            elapsed++;
            if (rdy[k]) begin
                if (k == N - 1) begin ph = PH_DONE; retries = 0; end
                else begin k++; elapsed = 0; end
            end else if (elapsed == T) begin
                if (retries < R) begin retries++; ph = PH_HOLD; elapsed = 0; end
                else ph = PH_ERR;
            end
        end else if (ph == PH_DONE) begin
            if (rdy != 3'b111) begin ph = PH_HOLD; elapsed = 0; retries = 0; end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.ro   = (ph == PH_DONE) ? 3'b000 :
                 (ph == PH_WAIT) ? 3'(7 & ~((2 << k) - 1)) : 3'b111;
        o.busy = (ph == PH_HOLD) || (ph == PH_WAIT);
        o.done = (ph == PH_DONE);
        o.err  = (ph == PH_ERR);
        o.rc   = 2'(retries);
        o.si   = (ph == PH_WAIT) ? 2'(k) : 2'd0;
        return o;
    endfunction

    task automatic cyc();
        obs_t e;
        logic [2:0] rdy;
        for (int i = 0; i < N; i++) begin
            age[i] = cur_ro[i] ? 0 : ((age[i] < 1000) ? age[i] + 1 : age[i]);
            rdy[i] = !drop[i] && (all_hi || (!stuck[i] && age[i] >= dly[i]));
        end
        stage_ready = rdy;
        model_edge(reset, soft_reset_req, rdy);
        e = model_obs();
        exp_q.push_back(e);
        cur_ro = e.ro;
        @(posedge clk_in);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic soft_pulse();
        soft_reset_req = 1'b1; cyc(); soft_reset_req = 1'b0;
    endtask

    always @(negedge clk_in) begin
        obs_t a, e;
        cycle++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {reset_out, seq_busy, seq_done, seq_error, retry_count, stage_index};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got ro=%b busy=%b done=%b err=%b rc=%0d si=%0d exp ro=%b busy=%b done=%b err=%b rc=%0d si=%0d",
                         cycle, a.ro, a.busy, a.done, a.err, a.rc, a.si,
                         e.ro, e.busy, e.done, e.err, e.rc, e.si);
            end
        end
    end

    initial begin
        // Reset state, then nominal bring-up with 2-cycle ready latency.
        reset = 1'b1; run(3);
        reset = 1'b0; run(30);
        // Runtime loss of stage 2 for one cycle while done.
        drop = 3'b100; cyc(); drop = 3'b000; run(30);
        // Stage 1 never ready: two retries then error.
        stuck = 3'b010; soft_pulse(); run(70);
        // Soft restart out of error with all ready high.
        stuck = 3'b000; all_hi = 1'b1; soft_pulse(); run(20);
        all_hi = 1'b0; run(30);
        // Ready exactly in the final wait cycle, then one cycle too late.
        dly = '{8, 2, 2}; soft_pulse(); run(40);
        dly = '{9, 2, 2}; soft_pulse(); run(60);
        // Reset mid-sequence.
        dly = '{2, 3, 1}; soft_pulse(); run(6);
        reset = 1'b1; cyc(); reset = 1'b0; run(30);
        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0)
                for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 10);
            if ($urandom_range(0, 299) == 0) stuck = 3'(1 << $urandom_range(0, 2));
            if ($urandom_range(0, 99) == 0) stuck = 3'b000;
            soft_reset_req = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 199) == 0);
            drop = ($urandom_range(0, 79) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            cyc();
        end
        soft_reset_req = 1'b0; reset = 1'b0; drop = 3'b000;
        repeat (3) @(posedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
